// File: rtl/digital_clock_pkg.sv
// ============================================================================
//  Module   : digital_clock_pkg
//  Purpose  : Shared BCD type, field limits and BCD increment helper for the
//             digital clock core.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package digital_clock_pkg;

  typedef logic [7:0] bcd8_t;

  localparam bcd8_t SEC_MAX     = 8'h59;
  localparam bcd8_t MIN_MAX     = 8'h59;
  localparam bcd8_t HOUR_MAX    = 8'h23;
  localparam bcd8_t CHIME_START = 8'h55;

  // Two-digit packed BCD +1 that wraps to 0x00 after max_val.
  function automatic bcd8_t bcd_inc(input bcd8_t v, input bcd8_t max_val);
    bcd8_t r_next;
    if (v == max_val) begin
      r_next = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r_next = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r_next = {v[7:4], v[3:0] + 4'd1};
    end
    return r_next;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digital_clock_core_bcd_counter.sv
// ============================================================================
//  Module   : bcd_counter
//  Purpose  : Two-digit BCD counter that wraps from MAX to 0x00 on inc and
//             flags the wrap on carry in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_counter
  import digital_clock_pkg::*;
#(
  parameter bcd8_t MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  bcd8_t r_value;

  // Count state: +1 in BCD per inc, wrap at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 8'h00;
    end else if (inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end
  end

  assign value = r_value;
  assign carry = inc && (r_value == MAX);

endmodule

`default_nettype wire

// File: rtl/digital_clock_core.sv
// ============================================================================
//  Module   : digital_clock_core
//  Purpose  : 24-hour HH:MM:SS time-of-day counter with BCD outputs, second
//             prescaler, edge-triggered hour/minute set buttons and optional
//             top-of-hour chime.
//  Config   : define CHIME_EN to build the chime decode on tweet; otherwise
//             tweet is tied low.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module digital_clock_core
  import digital_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       adjust_hour,
  input  logic       adjust_minute,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       tweet
);

  logic r_adj_hour_q;
  logic r_adj_min_q;
  logic w_tick;
  logic w_hour_rise;
  logic w_min_rise;
  logic w_sec_carry;
  logic w_min_carry;
  logic w_min_inc;
  logic w_hour_inc;

  // Second tick: either every enabled cycle or once per TICK_DIV enabled cycles.
  generate
    if (TICK_DIV <= 1) begin : g_tick_direct
      assign w_tick = en;
    end else begin : g_tick_prescale
      localparam int unsigned c_pw = $clog2(TICK_DIV);
      localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);

      logic [c_pw-1:0] r_presc;

      // Prescaler advances only while enabled and restarts after the tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_presc <= '0;
        end else if (en) begin
          r_presc <= (r_presc == c_last) ? '0 : r_presc + c_pw'(1);
        end
      end

      assign w_tick = en && (r_presc == c_last);
    end
  endgenerate

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adj_hour_q <= 1'b0;
      r_adj_min_q  <= 1'b0;
    end else begin
      r_adj_hour_q <= adjust_hour;
      r_adj_min_q  <= adjust_minute;
    end
  end

  assign w_hour_rise = adjust_hour & ~r_adj_hour_q;
  assign w_min_rise  = adjust_minute & ~r_adj_min_q;

  // A minute adjust coinciding with a seconds carry still moves minutes by
  // one only, and a minute wrap caused by an adjust never reaches the hours.
  assign w_min_inc  = w_sec_carry | w_min_rise;
  assign w_hour_inc = w_hour_rise | (w_min_carry & ~w_min_rise);

  bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_tick),
    .value (sec),
    .carry (w_sec_carry)
  );

  bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_min_inc),
    .value (min),
    .carry (w_min_carry)
  );

  bcd_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hour_inc),
    .value (hour),
    .carry ()
  );

`ifdef CHIME_EN
  // Pips over the last five seconds of the hour, then the strike at :00:00.
  assign tweet = ((min == MIN_MAX) && (sec >= CHIME_START) && (sec <= SEC_MAX)) ||
                 ((min == 8'h00) && (sec == 8'h00));
`else
  assign tweet = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_digital_clock_core.sv
// ============================================================================
//  Module   : tb_digital_clock_core
//  Purpose  : Self-checking bench for digital_clock_core against a
//             seconds-of-day reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digital_clock_core;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       adjust_hour;
  logic       adjust_minute;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       tweet;

  int n_checks;
  int n_errors;

  // Reference time as plain integers plus previous button levels.
  int m_h, m_m, m_s;
  bit m_ph, m_pm;

  digital_clock_core #(.TICK_DIV(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .adjust_hour   (adjust_hour),
    .adjust_minute (adjust_minute),
    .hour          (hour),
    .min           (min),
    .sec           (sec),
    .tweet         (tweet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit model_tweet(input int mm, input int ss);
`ifdef CHIME_EN
    model_tweet = ((mm == 59) && (ss >= 55)) || ((mm == 0) && (ss == 0));
`else
    model_tweet = 1'b0;
`endif
  endfunction

  // Clock edge in the model: advance seconds-of-day, then let any button
  // rise override its own field by exactly one.
  task automatic model_edge(input bit e, input bit ah, input bit am);
    int t, nh, nm, ns;
    bit rh, rm;
    rh = ah && !m_ph;
    rm = am && !m_pm;
    t  = m_h * 3600 + m_m * 60 + m_s;
    if (e) t = (t + 1) % 86400;
    nh = t / 3600;
    nm = (t / 60) % 60;
    ns = t % 60;
    if (rm) begin
      nm = (m_m + 1) % 60;
      nh = m_h;
    end
    if (rh) nh = (m_h + 1) % 24;
    m_h = nh; m_m = nm; m_s = ns;
    m_ph = ah; m_pm = am;
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_ph = 1'b0; m_pm = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".hour"}, hour, to_bcd(m_h));
    check_eq({tag, ".min"}, min, to_bcd(m_m));
    check_eq({tag, ".sec"}, sec, to_bcd(m_s));
    check_eq({tag, ".tweet"}, {7'd0, tweet}, {7'd0, model_tweet(m_m, m_s)});
  endtask

  task automatic step(input string tag, input bit e, input bit ah, input bit am);
    en = e; adjust_hour = ah; adjust_minute = am;
    @(posedge clk);
    model_edge(e, ah, am);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    en = 1'b0; adjust_hour = 1'b0; adjust_minute = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  task automatic hour_rises(input int n);
    for (int i = 0; i < n; i++) begin
      step("hr_rise", 1'b0, 1'b1, 1'b0);
      step("hr_fall", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic min_rises(input int n);
    for (int i = 0; i < n; i++) begin
      step("mn_rise", 1'b0, 1'b0, 1'b1);
      step("mn_fall", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step("run", 1'b1, 1'b0, 1'b0);
  endtask

  bit exp_tw[8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; en = 1'b0; adjust_hour = 1'b0; adjust_minute = 1'b0;
    model_reset();

    // Reset state, then frozen while en=0.
    #12;
    check_eq("rst.hour", hour, 8'h00);
    check_eq("rst.min", min, 8'h00);
    check_eq("rst.sec", sec, 8'h00);
    check_all("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("hold", 1'b0, 1'b0, 1'b0);
    check_eq("hold.sec", sec, 8'h00);

    // Sixty ticks: 00:00:00 -> 00:01:00, with 0x09 -> 0x10.
    for (int i = 0; i < 60; i++) begin
      step("count", 1'b1, 1'b0, 1'b0);
      if (i == 9) check_eq("sec09to10", sec, 8'h10);
    end
    check_eq("count.min", min, 8'h01);
    check_eq("count.sec", sec, 8'h00);

    // Day rollover.
    do_reset();
    hour_rises(23);
    min_rises(59);
    run(59);
    check_eq("pre_roll.hour", hour, 8'h23);
    check_eq("pre_roll.min", min, 8'h59);
    check_eq("pre_roll.sec", sec, 8'h59);
    run(1);
    check_eq("roll.hour", hour, 8'h00);
    check_eq("roll.min", min, 8'h00);
    check_eq("roll.sec", sec, 8'h00);

    // Held button counts once; hour and minute wraps without carry.
    do_reset();
    for (int i = 0; i < 10; i++) step("held", 1'b0, 1'b1, 1'b0);
    step("held_rel", 1'b0, 1'b0, 1'b0);
    check_eq("held.hour", hour, 8'h01);
    hour_rises(23);
    check_eq("hwrap.hour", hour, 8'h00);
    min_rises(60);
    check_eq("mwrap.min", min, 8'h00);
    check_eq("mwrap.hour", hour, 8'h00);

    // Chime window around the top of the hour.
`ifdef CHIME_EN
    exp_tw = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_tw = '{default: 1'b0};
`endif
    do_reset();
    min_rises(59);
    run(54);
    check_eq("chime0", {7'd0, tweet}, {7'd0, exp_tw[0]});
    for (int i = 1; i < 8; i++) begin
      run(1);
      check_eq("chime", {7'd0, tweet}, {7'd0, exp_tw[i]});
    end
    check_eq("chime.hour", hour, 8'h01);

    // Asynchronous reset between clock edges at 12:34:56.
    do_reset();
    hour_rises(12);
    min_rises(34);
    run(56);
    check_eq("t123456.hour", hour, 8'h12);
    check_eq("t123456.min", min, 8'h34);
    check_eq("t123456.sec", sec, 8'h56);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst.hour", hour, 8'h00);
    check_eq("arst.min", min, 8'h00);
    check_eq("arst.sec", sec, 8'h00);
    #1;
    rst_n = 1'b1;

    // Minute adjust in the same cycle as the seconds carry.
    min_rises(5);
    run(59);
    step("coincide", 1'b1, 1'b0, 1'b1);
    check_eq("coincide.min", min, 8'h06);
    check_eq("coincide.sec", sec, 8'h00);
    step("coincide_rel", 1'b1, 1'b0, 1'b0);

    // Adjust at 59 minutes together with the carry must not reach hours.
    do_reset();
    min_rises(59);
    run(59);
    step("adj_wrap", 1'b1, 1'b0, 1'b1);
    check_eq("adj_wrap.min", min, 8'h00);
    check_eq("adj_wrap.hour", hour, 8'h00);
    step("adj_wrap_rel", 1'b1, 1'b0, 1'b0);

    // Randomized enable and buttons, starting near the end of the day.
    do_reset();
    hour_rises(23);
    min_rises(58);
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
